// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, flag bit
// positions, FSM state encoding and the captured-operation record.
package alu_writeback_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_Q = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic        long_op;
      logic [3:0]  rd;
      logic [3:0]  rd_hi;
      logic [31:0] result;
      logic [31:0] result2;
   } wb_capture_t;

endpackage

// File: rtl/alu_writeback_condcheck.sv
// Condition-code evaluation against the current N,Z,C,V flags.
// Purely combinational; flags_nzcv is {N,Z,C,V}.
module alu_writeback_condcheck
   import alu_writeback_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags_nzcv,
   output logic       cond_ex
);

   logic flag_n;
   logic flag_z;
   logic flag_c;
   logic flag_v;

   assign flag_n = flags_nzcv[FLAG_N];
   assign flag_z = flags_nzcv[FLAG_Z];
   assign flag_c = flags_nzcv[FLAG_C];
   assign flag_v = flags_nzcv[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = flag_z;
         COND_NE: cond_ex = ~flag_z;
         COND_CS: cond_ex = flag_c;
         COND_CC: cond_ex = ~flag_c;
         COND_MI: cond_ex = flag_n;
         COND_PL: cond_ex = ~flag_n;
         COND_VS: cond_ex = flag_v;
         COND_VC: cond_ex = ~flag_v;
         COND_HI: cond_ex = flag_c & ~flag_z;
         COND_LS: cond_ex = ~flag_c | flag_z;
         COND_GE: cond_ex = (flag_n == flag_v);
         COND_LT: cond_ex = (flag_n != flag_v);
         COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
         COND_LE: cond_ex = flag_z | (flag_n != flag_v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: conditional flag update and one or two register-file
// writes per accepted op. Sticky Q flag is enabled by ALU_WB_STICKY_Q_EN.
//
// state    | meaning
// ST_IDLE  | no write pending, ready for a new op
// ST_WR_LO | writing Result to Rd (ready only if the op is not Long)
// ST_WR_HI | writing Result2 to RdHi, ready for a new op
module alu_writeback
   import alu_writeback_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] Result,
   input  logic [31:0] Result2,
   input  logic [4:0]  ALUFlags,
   input  logic [3:0]  Cond,
   input  logic [1:0]  FlagW,
   input  logic        RegW,
   input  logic        Long,
   input  logic [3:0]  Rd,
   input  logic [3:0]  RdHi,
   input  logic        ClearQ,
   output logic        WE3,
   output logic [3:0]  A3,
   output logic [31:0] WD3,
   output logic [4:0]  Flags,
   output logic        CondEx
);

   wb_state_e   state_q;
   wb_state_e   state_d;
   wb_capture_t cap_q;
   wb_capture_t cap_d;
   logic [3:0]  nzcv_q;
   logic [3:0]  nzcv_d;
   logic        accept;

   // Condition is judged against the flags as they stood before this op.
   alu_writeback_condcheck u_condcheck (
      .cond       (Cond),
      .flags_nzcv (nzcv_q),
      .cond_ex    (CondEx)
   );

   always_comb begin
      state_d  = ST_IDLE;
      in_ready = 1'b0;
      WE3      = 1'b0;
      A3       = 4'd0;
      WD3      = 32'd0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_WR_LO: begin
            WE3      = 1'b1;
            A3       = cap_q.rd;
            WD3      = cap_q.result;
            in_ready = ~cap_q.long_op;
         end
         ST_WR_HI: begin
            WE3      = 1'b1;
            A3       = cap_q.rd_hi;
            WD3      = cap_q.result2;
            in_ready = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase

      accept = in_valid & in_ready;

      if (accept) begin
         state_d = (CondEx & RegW) ? ST_WR_LO : ST_IDLE;
      end else if ((state_q == ST_WR_LO) && cap_q.long_op) begin
         state_d = ST_WR_HI;
      end
   end

   always_comb begin
      cap_d = cap_q;
      if (accept) begin
         cap_d.long_op = Long;
         cap_d.rd      = Rd;
         cap_d.rd_hi   = RdHi;
         cap_d.result  = Result;
         cap_d.result2 = Result2;
      end
   end

   always_comb begin
      nzcv_d = nzcv_q;
      if (accept && CondEx) begin
         if (FlagW[1]) begin
            nzcv_d[FLAG_N] = ALUFlags[FLAG_N];
            nzcv_d[FLAG_Z] = ALUFlags[FLAG_Z];
         end
         if (FlagW[0]) begin
            nzcv_d[FLAG_C] = ALUFlags[FLAG_C];
            nzcv_d[FLAG_V] = ALUFlags[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
         nzcv_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         nzcv_q  <= nzcv_d;
      end
   end

`ifdef ALU_WB_STICKY_Q_EN
   logic q_q;
   logic q_d;

   // Set is applied after clear so a coincident set wins.
   always_comb begin
      q_d = q_q;
      if (accept) begin
         if (ClearQ) begin
            q_d = 1'b0;
         end
         if (CondEx && ALUFlags[FLAG_Q]) begin
            q_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Flags = {q_q, nzcv_q};
`else
   logic unused_q_inputs;

   assign unused_q_inputs = ClearQ ^ ALUFlags[FLAG_Q];
   assign Flags           = {1'b0, nzcv_q};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: expected register writes are queued by
// the stimulus and consumed by a monitor; flag/handshake values checked inline.
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] Result;
   logic [31:0] Result2;
   logic [4:0]  ALUFlags;
   logic [3:0]  Cond;
   logic [1:0]  FlagW;
   logic        RegW;
   logic        Long;
   logic [3:0]  Rd;
   logic [3:0]  RdHi;
   logic        ClearQ;
   logic        WE3;
   logic [3:0]  A3;
   logic [31:0] WD3;
   logic [4:0]  Flags;
   logic        CondEx;

`ifdef ALU_WB_STICKY_Q_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
      string       tag;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   alu_writeback dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .Result   (Result),
      .Result2  (Result2),
      .ALUFlags (ALUFlags),
      .Cond     (Cond),
      .FlagW    (FlagW),
      .RegW     (RegW),
      .Long     (Long),
      .Rd       (Rd),
      .RdHi     (RdHi),
      .ClearQ   (ClearQ),
      .WE3      (WE3),
      .A3       (A3),
      .WD3      (WD3),
      .Flags    (Flags),
      .CondEx   (CondEx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      Result   = 32'd0;
      Result2  = 32'd0;
      ALUFlags = 5'd0;
      Cond     = COND_AL;
      FlagW    = 2'b00;
      RegW     = 1'b0;
      Long     = 1'b0;
      Rd       = 4'd0;
      RdHi     = 4'd0;
      ClearQ   = 1'b0;
   endtask

   task automatic op(input logic [3:0] c, input logic [1:0] fw, input logic rw,
                     input logic lg, input logic [3:0] rd_lo, input logic [3:0] rd_hi,
                     input logic [31:0] r_lo, input logic [31:0] r_hi,
                     input logic [4:0] af, input logic clr);
      in_valid = 1'b1;
      Cond     = c;
      FlagW    = fw;
      RegW     = rw;
      Long     = lg;
      Rd       = rd_lo;
      RdHi     = rd_hi;
      Result   = r_lo;
      Result2  = r_hi;
      ALUFlags = af;
      ClearQ   = clr;
   endtask

   task automatic expect_wr(input logic [3:0] a, input logic [31:0] d, input string tag);
      wr_t w;
      w.a   = a;
      w.d   = d;
      w.tag = tag;
      exp_q.push_back(w);
   endtask

   task automatic sweep(input logic [15:0] vec, input string tag);
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         Cond = 4'(i);
         #1;
         chk($sformatf("%s_cond%0d", tag, i), {31'd0, CondEx}, {31'd0, vec[i]});
      end
   endtask

   // Monitor: every write the DUT presents must match the head of the queue.
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && WE3 === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got A3=%0d WD3=%h required no write", A3, WD3);
            end else begin
               w = exp_q.pop_front();
               chk({w.tag, "_a3"}, {28'd0, A3}, {28'd0, w.a});
               chk({w.tag, "_wd3"}, WD3, w.d);
            end
         end
      end
   end

   initial begin
      idle_in();
      reset = 1'b0;
      step();
      step();
      chk("rst_we3", {31'd0, WE3}, 32'd0);
      chk("rst_a3", {28'd0, A3}, 32'd0);
      chk("rst_wd3", WD3, 32'd0);
      chk("rst_flags", {27'd0, Flags}, 32'd0);
      sweep(16'h56AA, "cc_zero");
      reset = 1'b1;
      #1;
      chk("rst_rel_ready", {31'd0, in_ready}, 32'd1);

      // Single write, one-cycle latency
      op(COND_AL, 2'b00, 1'b1, 1'b0, 4'd3, 4'd0, 32'h12345678, 32'h0, 5'd0, 1'b0);
      expect_wr(4'd3, 32'h12345678, "single");
      step();
      chk("single_we3_now", {31'd0, WE3}, 32'd1);
      idle_in();
      step();
      chk("single_we3_after", {31'd0, WE3}, 32'd0);

      // Long op with in_valid held
      op(COND_AL, 2'b00, 1'b1, 1'b1, 4'd4, 4'd5, 32'hAAAA0000, 32'h0000BBBB, 5'd0, 1'b0);
      expect_wr(4'd4, 32'hAAAA0000, "long_lo");
      expect_wr(4'd5, 32'h0000BBBB, "long_hi");
      step();
      chk("long_lo_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("long_hi_ready", {31'd0, in_ready}, 32'd1);
      idle_in();
      step();

      // Flag update, then a failing NE suppresses the write
      op(COND_AL, 2'b11, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00100, 1'b0);
      step();
      chk("flags_z", {27'd0, Flags}, 32'h04);
      op(COND_NE, 2'b11, 1'b1, 1'b0, 4'd6, 4'd0, 32'hDEADBEEF, 32'h0, 5'b01011, 1'b0);
      #1;
      chk("ne_condex", {31'd0, CondEx}, 32'd0);
      step();
      idle_in();
      step();
      chk("ne_flags_hold", {27'd0, Flags}, 32'h04);
      chk("ne_no_write", {31'd0, WE3}, 32'd0);

      // Selective flag writes and condition sweeps
      op(COND_AL, 2'b01, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00011, 1'b0);
      step();
      idle_in();
      chk("flagw01", {27'd0, Flags}, 32'h07);
      sweep(16'h6A65, "cc_zcv");
      op(COND_AL, 2'b11, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b01000, 1'b0);
      step();
      idle_in();
      chk("flagw11", {27'd0, Flags}, 32'h08);
      sweep(16'h6A9A, "cc_n");
      op(COND_AL, 2'b10, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00111, 1'b0);
      step();
      chk("flagw10", {27'd0, Flags}, 32'h04);

      // Sticky Q
      op(COND_AL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b10000, 1'b0);
      step();
      chk("q_set", {27'd0, Flags}, {27'd0, STICKY, 4'b0100});
      op(COND_AL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00000, 1'b0);
      step();
      chk("q_sticky", {27'd0, Flags}, {27'd0, STICKY, 4'b0100});
      op(COND_AL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00000, 1'b1);
      step();
      chk("q_clear", {27'd0, Flags}, 32'h04);
      op(COND_AL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b10000, 1'b1);
      step();
      chk("q_set_wins", {27'd0, Flags}, {27'd0, STICKY, 4'b0100});
      op(COND_AL, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b00000, 1'b1);
      step();
      op(COND_NV, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 5'b10000, 1'b0);
      step();
      idle_in();
      chk("q_nv_no_set", {27'd0, Flags}, 32'h04);

      // Long with Rd == RdHi: both writes, high last
      op(COND_AL, 2'b00, 1'b1, 1'b1, 4'd7, 4'd7, 32'h01010101, 32'h02020202, 5'd0, 1'b0);
      expect_wr(4'd7, 32'h01010101, "same_lo");
      expect_wr(4'd7, 32'h02020202, "same_hi");
      step();
      idle_in();
      step();
      step();

      // Non-accepted inputs must not disturb the capture or flags
      op(COND_AL, 2'b00, 1'b1, 1'b1, 4'd8, 4'd9, 32'h11111111, 32'h22222222, 5'd0, 1'b0);
      expect_wr(4'd8, 32'h11111111, "hold_lo");
      expect_wr(4'd9, 32'h22222222, "hold_hi");
      step();
      op(COND_AL, 2'b11, 1'b1, 1'b0, 4'd10, 4'd11, 32'h33333333, 32'h44444444, 5'b10011, 1'b0);
      step();
      idle_in();
      chk("hold_flags", {27'd0, Flags}, 32'h04);
      step();

      // Back-to-back singles
      for (int k = 1; k <= 3; k++) begin
         op(COND_AL, 2'b00, 1'b1, 1'b0, 4'(k), 4'd0, 32'hC0DE0000 + 32'(k), 32'h0, 5'd0, 1'b0);
         expect_wr(4'(k), 32'hC0DE0000 + 32'(k), $sformatf("b2b%0d", k));
         #1;
         chk($sformatf("b2b%0d_ready", k), {31'd0, in_ready}, 32'd1);
         step();
      end
      idle_in();
      step();

      // Accept in WR_HI following a long op
      op(COND_AL, 2'b00, 1'b1, 1'b1, 4'd13, 4'd14, 32'h13131313, 32'h14141414, 5'd0, 1'b0);
      expect_wr(4'd13, 32'h13131313, "chain_lo");
      expect_wr(4'd14, 32'h14141414, "chain_hi");
      step();
      step();
      op(COND_AL, 2'b00, 1'b1, 1'b0, 4'd2, 4'd0, 32'h5A5A5A5A, 32'h0, 5'd0, 1'b0);
      expect_wr(4'd2, 32'h5A5A5A5A, "chain_next");
      chk("chain_hi_ready", {31'd0, in_ready}, 32'd1);
      step();
      idle_in();
      step();
      step();

      // Reset during WR_LO of a long op drops both writes
      op(COND_AL, 2'b11, 1'b1, 1'b1, 4'd11, 4'd12, 32'hCAFE0000, 32'h0000CAFE, 5'b01010, 1'b0);
      step();
      idle_in();
      chk("rst_mid_we3_before", {31'd0, WE3}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid_we3", {31'd0, WE3}, 32'd0);
      chk("rst_mid_a3", {28'd0, A3}, 32'd0);
      chk("rst_mid_flags", {27'd0, Flags}, 32'd0);
      step();
      step();
      reset = 1'b1;
      repeat (4) step();
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-low (0 = reset asserted).
REQ-002 SHALL have ports: in_valid input 1 (ALU result presented); in_ready output 1 (stage can accept).
REQ-003 SHALL have ports: Result input 32 (low/only result); Result2 input 32 (high word); ALUFlags input 5, {Q,N,Z,C,V} from ALU.
REQ-004 SHALL have ports: Cond input 4 (condition code); FlagW input 2 ([1] update N,Z; [0] update C,V); RegW input 1 (write requested).
REQ-005 SHALL have ports: Long input 1 (two-register result); Rd input 4 (destination for Result); RdHi input 4 (destination for Result2); ClearQ input 1 (clear Q).
REQ-006 SHALL have ports: WE3 output 1, A3 output 4, WD3 output 32 (register-file write port); Flags output 5, {Q,N,Z,C,V}, registered; CondEx output 1.

Function
REQ-007 Accept SHALL occur on a rising clk edge with in_valid & in_ready.
REQ-008 CondEx SHALL be combinational from Cond and the current registered Flags (pre-update): EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V; HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 0.
REQ-009 On accept with CondEx=1: FlagW[1] loads N,Z; FlagW[0] loads C,V from ALUFlags; unselected flags hold.
REQ-010 Q SHALL be sticky: set on accept with CondEx=1 and ALUFlags[4]=1, independent of FlagW; cleared only by ClearQ=1 (synchronous) or reset; if set and clear occur in the same cycle, set wins.
REQ-011 FSM states IDLE, WR_LO, WR_HI; accept with CondEx&RegW -> WR_LO; accept otherwise -> IDLE (no write).
REQ-012 WR_LO: WE3=1, A3=Rd_q, WD3=Result_q; next WR_HI if Long_q, else per REQ-014.
REQ-013 WR_HI: WE3=1, A3=RdHi_q, WD3=Result2_q; next per REQ-014.
REQ-014 in_ready SHALL be 1 in IDLE, in WR_HI, and in WR_LO with Long_q=0; otherwise 0; from a final write state, accept -> per REQ-011, else -> IDLE.
REQ-015 Latency accept-to-first-write SHALL be exactly 1 cycle; throughput 1/cycle single, 1 per 2 cycles long.
REQ-016 In IDLE: WE3=0, A3=0, WD3=0.
REQ-017 Long with Rd==RdHi: both writes issue; RdHi/Result2 write is last and prevails.
REQ-018 Inputs not accepted (in_ready=0) SHALL NOT alter captured data or Flags.

Reset
REQ-019 reset=0 SHALL immediately force state IDLE, Flags=5'b0, WE3=0, A3=0, WD3=0, all captured registers 0.
REQ-020 Reset during WR_LO/WR_HI SHALL drop pending writes; no write after release until a new accept.
REQ-021 in_ready SHALL be 1 from reset release.

Configuration
REQ-022 Macro ALU_WB_STICKY_Q_EN: defined -> REQ-010 behaviour; undefined -> Flags[4] constant 0, ALUFlags[4] and ClearQ ignored, ports unchanged.

Structure
REQ-023 Shared package SHALL hold: condition-code constants (EQ..AL, NV), flag bit indices (Q=4,N=3,Z=2,C=1,V=0), FSM state enum.
REQ-024 Sub-module condcheck SHALL contain REQ-008 logic (Cond, Flags[3:0] in; CondEx out), purely combinational.

Verification
REQ-025 Reset then Cond=1110, RegW=1, Long=0, Rd=3, Result=0x12345678 -> next cycle WE3=1, A3=3, WD3=0x12345678; following cycle WE3=0.
REQ-026 Long=1, Rd=4, RdHi=5, Result=0xAAAA0000, Result2=0x0000BBBB, in_valid held -> cycle1 A3=4/0xAAAA0000, in_ready=0; cycle2 A3=5/0x0000BBBB, in_ready=1.
REQ-027 FlagW=11, ALUFlags=5'b00100 (Z) then Cond=0001 (NE), RegW=1 -> second op CondEx=0, no write, Flags=5'b00100.
REQ-028 Macro defined: ALUFlags[4]=1, FlagW=00 -> Q=1; later ops with ALUFlags[4]=0 keep Q=1; ClearQ=1 -> Q=0; ClearQ with ALUFlags[4]=1 same cycle -> Q=1.
REQ-029 reset=0 asserted mid-WR_LO of a Long op -> WE3=0 immediately, no WR_HI write after release, Flags=0.
REQ-030 Back-to-back single ops Rd=1,2,3 every cycle -> writes A3=1,2,3 on consecutive cycles, in_ready constantly 1.
